// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window scheduler: FSM state
// encodings, bank-index width helper and window element indexing.
package conv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PRIME   = 2'd1;
  localparam state_t ST_STREAM  = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // Bits needed to index one of nm line-buffer banks.
  function automatic int bank_w(input int nm);
    return $clog2(nm);
  endfunction

  // LSB of window element (r, c): r = 0 is the top row, c = 0 the leftmost column.
  function automatic int win_elem_lsb(input int r, input int c, input int kw, input int pb);
    return (r * kw + c) * pb;
  endfunction

endpackage

// File: rtl/conv_win_sched_if.sv
// Window output channel from the scheduler to the downstream MAC.
// Handshake: a window transfers on every rising clk edge where win_valid and
// win_ready are both 1. While win_valid is 1 and win_ready is 0, win_data and
// win_col hold their values. win_valid never depends on win_ready.
// frame_done is a one-cycle pulse outside the handshake.
interface conv_win_sched_if #(
  parameter int XB = 10,
  parameter int PB = 8,
  parameter int KW = 3
);
  logic                  win_valid;
  logic                  win_ready;
  logic [KW*KW*PB-1:0]   win_data;
  logic [XB-1:0]         win_col;
  logic                  frame_done;

  modport master (output win_valid, output win_data, output win_col, output frame_done,
                  input win_ready);
  modport slave  (input win_valid, input win_data, input win_col, input frame_done,
                  output win_ready);
endinterface

// File: rtl/conv_win_shift.sv
// KW x KW column shift register. Incoming bank-ordered pixels are reordered
// so that row 0 is always the pass's top bank, then shifted in at the right.
module conv_win_shift
  import conv_pkg::*;
#(
  parameter int PB = 8,
  parameter int NM = 4,
  parameter int KW = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shift_en,
  input  logic [$clog2(NM)-1:0]         top_bank,
  input  logic [NM-1:0][PB-1:0]         mem_data,
  output logic [KW*KW*PB-1:0]           win_data
);
  localparam int BW = bank_w(NM);

  logic [KW-1:0][PB-1:0]         col_in;
  logic [KW-1:0][KW-1:0][PB-1:0] win_d, win_q;

  // Reorder bank outputs into top-to-bottom window rows.
  always_comb begin
    for (int r = 0; r < KW; r++) begin
      col_in[r] = mem_data[top_bank + BW'(r)];
    end
  end

  // Shift all columns left by one and load the new column at the right edge.
  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      for (int r = 0; r < KW; r++) begin
        for (int c = 0; c < KW - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][KW-1] = col_in[r];
      end
    end
  end

  // Window register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_q <= '0;
    else     win_q <= win_d;
  end

  // Flatten into the output element layout.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < KW; r++) begin
      for (int c = 0; c < KW; c++) begin
        win_data[win_elem_lsb(r, c, KW, PB) +: PB] = win_q[r][c];
      end
    end
  end

endmodule

// File: rtl/conv_win_sched.sv
// Read-side scheduler for the NM-bank line buffer: waits for KW consecutive
// full banks, sweeps a common column across them to build KW x KW windows,
// then returns consumed banks (one per row, all KW at frame end).
module conv_win_sched
  import conv_pkg::*;
#(
  parameter int XB = 10,
  parameter int YB = 10,
  parameter int PB = 8,
  parameter int NM = 4,
  parameter int KW = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [XB-1:0]                 cfg_width,
  input  logic [YB-1:0]                 cfg_height,
  input  logic [NM-1:0]                 mb_full,
  input  logic [NM-1:0][PB-1:0]         mem_data,
  output logic [NM-1:0][XB-1:0]         mb_rd_addr,
  output logic [NM-1:0]                 mem_used,
  conv_win_sched_if.master              win,
  output state_t                        dbg_state,
  output logic [NM-1:0]                 dbg_ready,
  output logic [$clog2(NM)-1:0]         dbg_top_bank,
  output logic [YB-1:0]                 dbg_row_pass
);
  localparam int BW = bank_w(NM);

  state_t          state_d, state_q;
  logic [NM-1:0]   ready_d, ready_q;
  logic [BW-1:0]   top_d, top_q;
  logic [YB-1:0]   row_d, row_q;
  logic [XB-1:0]   col_ptr_d, col_ptr_q;
  logic [XB-1:0]   ld_d, ld_q;
  logic [XB-1:0]   cfg_w_d, cfg_w_q;
  logic [YB-1:0]   cfg_h_d, cfg_h_q;
  logic [XB-1:0]   win_col_d, win_col_q;

  logic [NM-1:0]   pass_mask;
  logic [NM-1:0]   rel_mask;
  logic [XB-1:0]   rd_col;
  logic            shift_en;
  logic            frame_done;
  logic            last_win;
  logic            last_row;
  logic [KW*KW*PB-1:0] win_data_w;

  // Banks belonging to the current pass, in ring order from top_bank.
  always_comb begin
    pass_mask = '0;
    for (int r = 0; r < KW; r++) begin
      pass_mask[top_q + BW'(r)] = 1'b1;
    end
  end

  assign last_win = (win_col_q == cfg_w_q - XB'(KW));
  assign last_row = (row_q == cfg_h_q - YB'(KW));

  // Pass sequencing; in STREAM the read address looks one column ahead on
  // acceptance so the next column's data lands in time for back-to-back windows.
  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    row_d     = row_q;
    col_ptr_d = col_ptr_q;
    ld_d      = ld_q;
    cfg_w_d   = cfg_w_q;
    cfg_h_d   = cfg_h_q;
    win_col_d = win_col_q;
    rd_col    = '0;
    shift_en  = 1'b0;
    rel_mask  = '0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((ready_q & pass_mask) == pass_mask) begin
          state_d   = ST_PRIME;
          ld_d      = '0;
          cfg_w_d   = cfg_width;
          cfg_h_d   = cfg_height;
          win_col_d = '0;
        end
      end
      ST_PRIME: begin
        // ld_q doubles as the read column; data for column ld_q-1 is on mem_data.
        rd_col   = ld_q;
        shift_en = (ld_q != '0);
        ld_d     = ld_q + XB'(1);
        if (ld_q == XB'(KW)) begin
          state_d   = ST_STREAM;
          col_ptr_d = XB'(KW);
        end
      end
      ST_STREAM: begin
        rd_col = col_ptr_q;
        if (win.win_ready) begin
          if (last_win) begin
            state_d = ST_RELEASE;
          end else begin
            shift_en  = 1'b1;
            rd_col    = col_ptr_q + XB'(1);
            col_ptr_d = col_ptr_q + XB'(1);
            win_col_d = win_col_q + XB'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (last_row) begin
          rel_mask   = pass_mask;
          top_d      = top_q + BW'(KW);
          row_d      = '0;
          frame_done = 1'b1;
        end else begin
          rel_mask[top_q] = 1'b1;
          top_d           = top_q + BW'(1);
          row_d           = row_q + YB'(1);
        end
      end
    endcase
  end

  // Ready flags: set by the memory unit, cleared only by our own release.
  assign ready_d = (ready_q | mb_full) & ~rel_mask;

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= '0;
      top_q     <= '0;
      row_q     <= '0;
      col_ptr_q <= '0;
      ld_q      <= '0;
      cfg_w_q   <= '0;
      cfg_h_q   <= '0;
      win_col_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      top_q     <= top_d;
      row_q     <= row_d;
      col_ptr_q <= col_ptr_d;
      ld_q      <= ld_d;
      cfg_w_q   <= cfg_w_d;
      cfg_h_q   <= cfg_h_d;
      win_col_q <= win_col_d;
    end
  end

  // Pass banks share the read column; other banks are parked at 0.
  always_comb begin
    for (int i = 0; i < NM; i++) begin
      mb_rd_addr[i] = pass_mask[i] ? rd_col : '0;
    end
  end

  conv_win_shift #(.PB(PB), .NM(NM), .KW(KW)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .top_bank (top_q),
    .mem_data (mem_data),
    .win_data (win_data_w)
  );

  assign mem_used       = rel_mask;
  assign win.win_valid  = (state_q == ST_STREAM);
  assign win.win_data   = win_data_w;
  assign win.win_col    = win_col_q;
  assign win.frame_done = frame_done;

  assign dbg_state    = state_q;
  assign dbg_ready    = ready_q;
  assign dbg_top_bank = top_q;
  assign dbg_row_pass = row_q;

endmodule

// File: tb/tb_conv_win_sched.sv
// Directed bench for conv_win_sched: basic pass, backpressure, ring wrap,
// mid-pass reset, simultaneous set/release and frame end.
module tb_conv_win_sched;
  import conv_pkg::*;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int PB = 8;
  localparam int NM = 4;
  localparam int KW = 3;

  logic                  clk;
  logic                  rst;
  logic [XB-1:0]         cfg_width;
  logic [YB-1:0]         cfg_height;
  logic [NM-1:0]         mb_full;
  logic [NM-1:0][PB-1:0] mem_data;
  logic [NM-1:0][XB-1:0] mb_rd_addr;
  logic [NM-1:0]         mem_used;
  state_t                dbg_state;
  logic [NM-1:0]         dbg_ready;
  logic [1:0]            dbg_top_bank;
  logic [YB-1:0]         dbg_row_pass;

  int n_tests = 0;
  int n_fail  = 0;

  conv_win_sched_if #(.XB(XB), .PB(PB), .KW(KW)) win_if ();

  conv_win_sched #(.XB(XB), .YB(YB), .PB(PB), .NM(NM), .KW(KW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .mb_full      (mb_full),
    .mem_data     (mem_data),
    .mb_rd_addr   (mb_rd_addr),
    .mem_used     (mem_used),
    .win          (win_if),
    .dbg_state    (dbg_state),
    .dbg_ready    (dbg_ready),
    .dbg_top_bank (dbg_top_bank),
    .dbg_row_pass (dbg_row_pass)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pixel stored at (bank, column): bank in the high bits, column low.
  function automatic logic [PB-1:0] pix(input int b, input int col);
    return PB'((b * 64 + col) & 255);
  endfunction

  // Line-buffer memory model with one-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < NM; b++) mem_data[b] <= pix(b, int'(mb_rd_addr[b]));
  end

  // Expected window: row r from bank (top+r) mod NM, columns col..col+KW-1.
  function automatic logic [KW*KW*PB-1:0] exp_win(input int top, input int col);
    logic [KW*KW*PB-1:0] v;
    v = '0;
    for (int r = 0; r < KW; r++)
      for (int c = 0; c < KW; c++)
        v[(r*KW+c)*PB +: PB] = pix((top + r) % NM, col + c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_full(input logic [NM-1:0] m);
    mb_full = m;
    @(negedge clk);
    mb_full = '0;
  endtask

  // Runs one row pass; called at a negedge, returns at the negedge of the
  // IDLE cycle that follows RELEASE.
  task automatic run_pass(input int top, input int width, input int stall_col,
                          input int stall_len, input logic [NM-1:0] exp_rel,
                          input logic exp_fd, input int top_after, input int row_after,
                          input logic [NM-1:0] rel_full, input logic [NM-1:0] ready_after,
                          input logic chk_lat);
    int cyc, lat, nwin, exp_n, stall_left;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (dbg_state != ST_PRIME && cyc < 50);
    chk("enter_prime", dbg_state, ST_PRIME);
    lat = 0;
    while (!win_if.win_valid && lat < 20) begin @(negedge clk); lat++; end
    if (chk_lat) chk("first_valid_latency", lat, 4);
    exp_n = width - KW + 1;
    nwin = 0;
    stall_left = stall_len;
    cyc = 0;
    while (nwin < exp_n && cyc < 200) begin
      chk("win_valid", win_if.win_valid, 1'b1);
      chk("win_col", win_if.win_col, nwin);
      chk("win_data", win_if.win_data, exp_win(top, nwin));
      chk("addr_idle_bank", mb_rd_addr[(top + KW) % NM], 0);
      if (nwin < exp_n - 1)
        chk("addr_pass_bank", mb_rd_addr[top], nwin + KW + (win_if.win_ready ? 1 : 0));
      if (nwin == stall_col && stall_left > 0) begin
        win_if.win_ready = 1'b0;
        stall_left--;
      end else begin
        win_if.win_ready = 1'b1;
        nwin++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("window_count", nwin, exp_n);
    chk("release_state", dbg_state, ST_RELEASE);
    chk("release_valid_low", win_if.win_valid, 1'b0);
    chk("mem_used", mem_used, exp_rel);
    chk("frame_done", win_if.frame_done, exp_fd);
    mb_full = rel_full;
    @(negedge clk);
    mb_full = '0;
    chk("idle_after_release", dbg_state, ST_IDLE);
    chk("mem_used_cleared", mem_used, 0);
    chk("frame_done_cleared", win_if.frame_done, 1'b0);
    chk("top_bank", dbg_top_bank, top_after);
    chk("row_pass", dbg_row_pass, row_after);
    chk("ready_flags", dbg_ready, ready_after);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_win_valid"}, win_if.win_valid, 1'b0);
    chk({pfx, "_win_data"}, win_if.win_data, 0);
    chk({pfx, "_win_col"}, win_if.win_col, 0);
    chk({pfx, "_mem_used"}, mem_used, 0);
    chk({pfx, "_frame_done"}, win_if.frame_done, 1'b0);
    chk({pfx, "_rd_addr"}, mb_rd_addr, 0);
    chk({pfx, "_state"}, dbg_state, ST_IDLE);
    chk({pfx, "_ready"}, dbg_ready, 0);
    chk({pfx, "_top_bank"}, dbg_top_bank, 0);
    chk({pfx, "_row_pass"}, dbg_row_pass, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    mb_full = '0;
    cfg_width = XB'(8);
    cfg_height = YB'(8);
    win_if.win_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic pass: banks 0..2, width 8 -> 6 windows, release bank 0.
    pulse_full(4'b0111);
    run_pass(0, 8, -1, 0, 4'b0001, 1'b0, 1, 1, 4'b0000, 4'b0110, 1'b1);

    // Backpressure: banks 1..3, 3-cycle stall at column 2.
    pulse_full(4'b1000);
    run_pass(1, 8, 2, 3, 4'b0010, 1'b0, 2, 2, 4'b0000, 4'b1100, 1'b0);

    // Ring wrap: banks 2,3,0; row 0 from bank 2, row 2 from bank 0.
    pulse_full(4'b0001);
    run_pass(2, 8, -1, 0, 4'b0100, 1'b0, 3, 3, 4'b0000, 4'b1001, 1'b0);

    // Reset in the middle of streaming.
    pulse_full(4'b0010);
    cyc = 0;
    while (!win_if.win_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("reach_stream", win_if.win_valid, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", dbg_state, ST_IDLE);
    chk("post_rst_ready", dbg_ready, 0);

    // Frame of width 4, height 5: three passes of two windows.
    // First release coincides with mb_full on bank 3 (set) and bank 0 (release wins).
    cfg_width = XB'(4);
    cfg_height = YB'(5);
    pulse_full(4'b0111);
    run_pass(0, 4, -1, 0, 4'b0001, 1'b0, 1, 1, 4'b1001, 4'b1110, 1'b0);
    run_pass(1, 4, -1, 0, 4'b0010, 1'b0, 2, 2, 4'b0000, 4'b1100, 1'b0);
    pulse_full(4'b0001);
    run_pass(2, 4, -1, 0, 4'b1101, 1'b1, 1, 0, 4'b0000, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
